// File: rtl/mul_add_flow_ctrl.sv
// Valid/ready shell around a fixed-latency, non-stallable multiply-add pipeline.
// Optional statistics counters are enabled with `define MUL_ADD_FLOW_STATS_EN.
module mul_add_flow_ctrl #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic [31:0] in_z,
  output logic [31:0] pipe_x,
  output logic [31:0] pipe_y,
  output logic [31:0] pipe_z,
  input  logic [31:0] pipe_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
`ifdef MUL_ADD_FLOW_STATS_EN
  ,
  output logic [31:0] stat_accepted,
  output logic [31:0] stat_popped,
  output logic [31:0] stat_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(DEPTH + 1);
  localparam logic [RW-1:0] RESV_MAX = RW'(DEPTH);
  localparam logic [RW-1:0] RESV_ONE = RW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  logic [RW-1:0]      resv_q, resv_d;
  logic [LATENCY-1:0] tok_q, tok_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [31:0]        mem_q [DEPTH];

  logic acc, pop, push, full, empty;

  // resv counts every op accepted but not yet popped, in flight or queued,
  // so it is the credit that keeps the FIFO from ever overflowing.
  assign in_ready = rst | (resv_q < RESV_MAX);
  assign acc      = in_valid & in_ready & ~rst;

  assign pipe_x = acc ? in_x : 32'h0;
  assign pipe_y = acc ? in_y : 32'h0;
  assign pipe_z = acc ? in_z : 32'h0;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push      = tok_q[LATENCY-1];
  assign out_valid = ~empty & ~rst;
  assign pop       = out_valid & out_ready;
  assign out_data  = rst ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    resv_d   = resv_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tok_d    = '0;
    if (acc && !pop)      resv_d = resv_q + RESV_ONE;
    else if (!acc && pop) resv_d = resv_q - RESV_ONE;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    tok_d[0] = acc;
    for (int i = 1; i < LATENCY; i++) tok_d[i] = tok_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resv_q   <= '0;
      tok_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else begin
      resv_q   <= resv_d;
      tok_q    <= tok_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= pipe_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full && !pop));
  end

`ifdef MUL_ADD_FLOW_STATS_EN
  logic [31:0] st_acc_q, st_pop_q, st_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_acc_q   <= 32'h0;
      st_pop_q   <= 32'h0;
      st_stall_q <= 32'h0;
    end else begin
      if (acc)                  st_acc_q   <= st_acc_q + 32'd1;
      if (pop)                  st_pop_q   <= st_pop_q + 32'd1;
      if (in_valid && !in_ready) st_stall_q <= st_stall_q + 32'd1;
    end
  end

  assign stat_accepted = rst ? 32'h0 : st_acc_q;
  assign stat_popped   = rst ? 32'h0 : st_pop_q;
  assign stat_stall    = rst ? 32'h0 : st_stall_q;
`endif

endmodule
